register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and of every data port.
REQ-002 Parameter NUM_REGS, default 16, number of architectural registers.
REQ-003 Parameter ADDR_WIDTH, default 4, register index width; SHALL equal clog2(NUM_REGS).
REQ-004 clk  input  1  single clock; all writes occur on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 dataOut0  output  DATA_WIDTH  read port 0 data.
REQ-007 regNum0  input  ADDR_WIDTH  read port 0 register index.
REQ-008 dataOut1  output  DATA_WIDTH  read port 1 data.
REQ-009 regNum1  input  ADDR_WIDTH  read port 1 register index.
REQ-010 wDataIn  input  DATA_WIDTH  write port data.
REQ-011 wRegNum  input  ADDR_WIDTH  write port register index.
REQ-012 writeEnable  input  1  1 = write on the next rising clk edge; 0 = read only.
REQ-013 Port order SHALL be clk, reset, dataOut0, regNum0, dataOut1, regNum1, wDataIn, wRegNum, writeEnable.

Function
REQ-014 Storage SHALL be an unpacked array named registers[0:NUM_REGS-1] of DATA_WIDTH bits, hierarchically accessible to benches, including preload by direct assignment.
REQ-015 Register 0 SHALL always read as 0; writes to index 0 SHALL be discarded.
REQ-016 On a rising clk edge with reset deasserted, writeEnable=1 and wRegNum!=0, registers[wRegNum] SHALL take wDataIn; all other registers SHALL be unchanged.
REQ-017 With writeEnable=0, no register SHALL change, regardless of wDataIn or wRegNum.
REQ-018 dataOut0 SHALL combinationally equal registers[regNum0] (0 when regNum0=0), with zero clock latency.
REQ-019 dataOut1 SHALL combinationally equal registers[regNum1] (0 when regNum1=0), independently of port 0.
REQ-020 Both read ports SHALL be able to address the same register simultaneously and return identical data.
REQ-021 Read-during-write to the same index SHALL return the stored (old) value until the clk edge, then the new value; no write-to-read bypass.
REQ-022 Exactly one write port; a write SHALL modify exactly one register.

Reset
REQ-023 While reset=0, all registers 1..NUM_REGS-1 SHALL be cleared to 0 immediately, without waiting for clk.
REQ-024 While reset=0, writes SHALL be blocked even if writeEnable=1.
REQ-025 Both dataOut ports SHALL read 0 during reset for any index.
REQ-026 Reset deasserting between clk edges SHALL allow a write on the very next rising edge.

Structure
REQ-027 DATA_WIDTH, NUM_REGS and ADDR_WIDTH defaults SHALL live in a shared package, cpu_pkg, with a reg_idx_t typedef (ADDR_WIDTH bits) and a word_t typedef (DATA_WIDTH bits).
REQ-028 One sub-module, register_bank_read_port (index in, data out, zero-index masking), SHALL be instantiated twice.

Verification
REQ-029 For each i=1..15: reset, write 0xFFFFFFFF to reg i -> registers[i]=0xFFFFFFFF, every other register j in 1..15 = 0.
REQ-030 After REQ-029 write, writeEnable=0, wDataIn=0xF0F0F0F0, one clk edge -> dataOut0=dataOut1=0xFFFFFFFF, registers[i] unchanged.
REQ-031 Write 0x12345678 to index 0 -> registers[0] reads 0, dataOut0 with regNum0=0 is 0.
REQ-032 regNum0=3, regNum1=7 with reg3=0xA5A5A5A5, reg7=0x5A5A5A5A -> dataOut0=0xA5A5A5A5, dataOut1=0x5A5A5A5A, with no clk edge required.
REQ-033 Assert reset (0) mid-cycle with reg5=0xDEADBEEF -> reg5 reads 0 before the next clk edge; writeEnable=1 during reset leaves all registers 0.
REQ-034 Write 0x0000CAFE to reg2 while regNum0=2 -> dataOut0 shows old value before the edge and 0x0000CAFE after it.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath parameters and basic types used by the register bank.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/register_bank_read_port.sv
// Combinational read port: selects one register, forcing index 0 (and out-of-range) to zero.
module register_bank_read_port
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = cpu_pkg::NUM_REGS,
  parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] regs_i [NUM_REGS],
  input  logic [ADDR_WIDTH-1:0] idx_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = '0;
    if ((idx_i != '0) && (32'(idx_i) < NUM_REGS)) begin
      data_o = regs_i[idx_i];
    end
  end

endmodule

// File: rtl/register_bank.sv
// Two-read, one-write architectural register file with a hardwired-zero register 0.
module register_bank
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = cpu_pkg::NUM_REGS,
  parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] dataOut0,
  input  logic [ADDR_WIDTH-1:0] regNum0,
  output logic [DATA_WIDTH-1:0] dataOut1,
  input  logic [ADDR_WIDTH-1:0] regNum1,
  input  logic [DATA_WIDTH-1:0] wDataIn,
  input  logic [ADDR_WIDTH-1:0] wRegNum,
  input  logic                  writeEnable
);

  logic [DATA_WIDTH-1:0] registers [0:NUM_REGS-1];
  logic                  wr_hit;

  assign wr_hit = writeEnable && (wRegNum != '0) && (32'(wRegNum) < NUM_REGS);

  // Register 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        registers[i] <= '0;
      end
    end else if (wr_hit) begin
      registers[wRegNum] <= wDataIn;
    end
  end

  register_bank_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd0 (
    .regs_i (registers),
    .idx_i  (regNum0),
    .data_o (dataOut0)
  );

  register_bank_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd1 (
    .regs_i (registers),
    .idx_i  (regNum1),
    .data_o (dataOut1)
  );

endmodule

// File: tb/tb_register_bank.sv
// Directed plus randomized checks of register_bank against an array-based reference model.
module tb_register_bank;
  import cpu_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  word_t    dataOut0, dataOut1, wDataIn;
  reg_idx_t regNum0, regNum1, wRegNum;
  logic     writeEnable;

  int tests_run = 0;
  int tests_failed = 0;
  word_t mdl [16];

  always #5 clk = ~clk;

  register_bank dut (
    .clk         (clk),
    .reset       (reset),
    .dataOut0    (dataOut0),
    .regNum0     (regNum0),
    .dataOut1    (dataOut1),
    .regNum1     (regNum1),
    .wDataIn     (wDataIn),
    .wRegNum     (wRegNum),
    .writeEnable (writeEnable)
  );

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int j = 0; j < 16; j++) chk($sformatf("%s reg%0d", tag, j), dut.registers[j], j == 0 ? 32'h0 : mdl[j]);
  endtask

  task automatic mdl_clear();
    for (int j = 0; j < 16; j++) mdl[j] = 32'h0;
  endtask

  // Reference reading rule: index 0 and any index during reset read zero.
  function automatic word_t mdl_read(input int idx);
    return (idx == 0 || reset == 1'b0) ? 32'h0 : mdl[idx];
  endfunction

  task automatic do_write(input int idx, input word_t data);
    @(negedge clk);
    writeEnable = 1'b1; wRegNum = 4'(idx); wDataIn = data;
    @(posedge clk); #1;
    if (idx != 0) mdl[idx] = data;
    writeEnable = 1'b0;
  endtask

  initial begin
    reset = 1'b0; writeEnable = 1'b0; wDataIn = '0; wRegNum = '0; regNum0 = '0; regNum1 = '0;
    mdl_clear();

    // Reset state.
    #2;
    chk_regs("reset");
    regNum0 = 4'd9; regNum1 = 4'd15; #1;
    chk("reset_rd0", dataOut0, 32'h0);
    chk("reset_rd1", dataOut1, 32'h0);
    #9 reset = 1'b1;  // released between edges

    // Walk an all-ones value through each register after a fresh reset.
    for (int i = 1; i < 16; i++) begin
      @(negedge clk); #1 reset = 1'b0; #1 reset = 1'b1;
      mdl_clear();
      writeEnable = 1'b1; wRegNum = 4'(i); wDataIn = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      mdl[i] = 32'hFFFF_FFFF;
      chk_regs($sformatf("walk%0d", i));
      writeEnable = 1'b0; wDataIn = 32'hF0F0_F0F0; regNum0 = 4'(i); regNum1 = 4'(i);
      @(posedge clk); #1;
      chk($sformatf("hold%0d rd0", i), dataOut0, 32'hFFFF_FFFF);
      chk($sformatf("hold%0d rd1", i), dataOut1, 32'hFFFF_FFFF);
      chk($sformatf("hold%0d reg", i), dut.registers[i], 32'hFFFF_FFFF);
    end

    // Writes to register 0 are discarded.
    do_write(0, 32'h1234_5678);
    regNum0 = 4'd0; #1;
    chk("zero_reg", dut.registers[0], 32'h0);
    chk("zero_rd0", dataOut0, 32'h0);

    // Independent combinational reads.
    do_write(3, 32'hA5A5_A5A5);
    do_write(7, 32'h5A5A_5A5A);
    @(negedge clk);
    regNum0 = 4'd3; regNum1 = 4'd7; #1;
    chk("dual_rd0", dataOut0, 32'hA5A5_A5A5);
    chk("dual_rd1", dataOut1, 32'h5A5A_5A5A);

    // Read-during-write returns old data until the edge.
    do_write(2, 32'h1111_2222);
    @(negedge clk);
    regNum0 = 4'd2; writeEnable = 1'b1; wRegNum = 4'd2; wDataIn = 32'h0000_CAFE; #1;
    chk("rdw_before", dataOut0, 32'h1111_2222);
    @(posedge clk); #1;
    mdl[2] = 32'h0000_CAFE;
    chk("rdw_after", dataOut0, 32'h0000_CAFE);
    writeEnable = 1'b0;

    // Asynchronous reset mid-cycle, writes blocked while held.
    do_write(5, 32'hDEAD_BEEF);
    @(negedge clk);
    regNum0 = 4'd5; #1;
    chk("pre_rst", dataOut0, 32'hDEAD_BEEF);
    reset = 1'b0; #1;
    mdl_clear();
    chk("async_rst_reg5", dut.registers[5], 32'h0);
    chk("async_rst_rd0", dataOut0, 32'h0);
    writeEnable = 1'b1; wRegNum = 4'd5; wDataIn = 32'h7777_7777;
    @(posedge clk); #1;
    chk_regs("rst_blocks_wr");
    @(negedge clk); #1 reset = 1'b1;
    wRegNum = 4'd6; wDataIn = 32'h0BAD_F00D;
    @(posedge clk); #1;
    mdl[6] = 32'h0BAD_F00D;
    chk("wr_after_rst", dut.registers[6], 32'h0BAD_F00D);
    writeEnable = 1'b0;

    // Randomized traffic against the model, with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      int we, wr, r0, r1;
      word_t wd;
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        #1 reset = 1'b0; #1;
        mdl_clear();
        chk("rnd_rst_rd0", dataOut0, 32'h0);
        reset = 1'b1;
      end
      we = int'($urandom_range(0, 1));
      wr = int'($urandom_range(0, 15));
      r0 = int'($urandom_range(0, 15));
      r1 = ($urandom_range(0, 3) == 0) ? r0 : int'($urandom_range(0, 15));
      wd = $urandom;
      writeEnable = we[0]; wRegNum = 4'(wr); wDataIn = wd;
      regNum0 = 4'(r0); regNum1 = 4'(r1); #1;
      chk("rnd_pre_rd0", dataOut0, mdl_read(r0));
      chk("rnd_pre_rd1", dataOut1, mdl_read(r1));
      @(posedge clk); #1;
      if (we != 0 && wr != 0) mdl[wr] = wd;
      chk("rnd_post_rd0", dataOut0, mdl_read(r0));
      chk("rnd_post_rd1", dataOut1, mdl_read(r1));
    end
    writeEnable = 1'b0;
    #1;
    chk_regs("rnd_final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
